// File: rtl/matrix_slot_allocator_if.sv
// Request/grant/commit handshake between the UART input stage and the slot allocator.
//   req_valid/req_m/req_n : dimension request, held until addr_ready (input stage -> allocator)
//   addr_ready            : 1-cycle grant pulse; base_addr/alloc_id/replaced valid with it
//   base_addr/alloc_id    : granted slot base word address and index (held until next grant)
//   replaced              : grant overwrote a live matrix
//   req_error             : 1-cycle pulse, illegal dimensions dropped
//   commit                : pulse, matrix fully written
//   abort                 : level, input stage disabled; cancels pending grant
interface matrix_slot_allocator_if;
    logic       req_valid;
    logic [2:0] req_m;
    logic [2:0] req_n;
    logic       addr_ready;
    logic [8:0] base_addr;
    logic [3:0] alloc_id;
    logic       replaced;
    logic       req_error;
    logic       commit;
    logic       abort;

    modport master (
        output req_valid, req_m, req_n, commit, abort,
        input  addr_ready, base_addr, alloc_id, replaced, req_error
    );

    modport slave (
        input  req_valid, req_m, req_n, commit, abort,
        output addr_ready, base_addr, alloc_id, replaced, req_error
    );
endinterface

// File: rtl/matrix_slot_allocator.sv
// Matrix slot allocator: picks a slot in the 512-word matrix RAM for each incoming
// matrix, commits its descriptor on completion and serves descriptor lookups.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request/grant/commit handshake (slave side)
//   busy        : high whenever the allocator is not idle
//   query_id    : descriptor lookup index
//   query_valid/query_m/query_n/query_base : combinational descriptor read of query_id
module matrix_slot_allocator #(
    parameter int unsigned MAX_MATS    = 16,
    parameter int unsigned SLOT_WORDS  = 25,
    parameter int unsigned MAX_PER_DIM = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_slot_allocator_if.slave  bus,
    output logic                    busy,
    input  logic [3:0]              query_id,
    output logic                    query_valid,
    output logic [2:0]              query_m,
    output logic [2:0]              query_n,
    output logic [8:0]              query_base
);
    localparam int unsigned ID_W  = 4;
    localparam int unsigned CNT_W = $clog2(MAX_MATS + 1);
    localparam int unsigned ST_W  = 8;
    localparam int unsigned AW    = 9;

    typedef struct packed {
        logic            valid;
        logic [2:0]      m;
        logic [2:0]      n;
        logic [ST_W-1:0] stamp;
    } desc_t;

    typedef enum logic [1:0] {IDLE, SCAN, GRANT, WAIT_COMMIT} state_t;

    state_t            state_q;
    desc_t             desc_q [MAX_MATS];
    logic [ST_W-1:0]   stamp_q;
    logic [2:0]        m_q, n_q;
    logic [ID_W-1:0]   scan_idx;
    logic              free_found_q, any_found_q;
    logic [ID_W-1:0]   free_idx_q, old_idx_q, same_idx_q;
    logic [ST_W-1:0]   old_age_q, same_age_q;
    logic [CNT_W-1:0]  same_cnt_q;

    logic              nx_free_found, nx_any_found;
    logic [ID_W-1:0]   nx_free_idx, nx_old_idx, nx_same_idx;
    logic [ST_W-1:0]   nx_old_age, nx_same_age;
    logic [CNT_W-1:0]  nx_same_cnt;
    logic [ID_W-1:0]   victim;
    logic              victim_rep;
    desc_t             slot;
    logic [ST_W-1:0]   age;
    logic              dims_legal;

    assign dims_legal = (bus.req_m != 3'd0) && (bus.req_m <= 3'd5) &&
                        (bus.req_n != 3'd0) && (bus.req_n <= 3'd5);

    // Fold the slot under scan into the trackers and pick the victim from the
    // updated values, so the last scan cycle can launch the grant directly.
    always_comb begin
        slot          = desc_q[scan_idx];
        age           = stamp_q - slot.stamp;
        nx_free_found = free_found_q;
        nx_free_idx   = free_idx_q;
        nx_any_found  = any_found_q;
        nx_old_idx    = old_idx_q;
        nx_old_age    = old_age_q;
        nx_same_cnt   = same_cnt_q;
        nx_same_idx   = same_idx_q;
        nx_same_age   = same_age_q;
        victim        = '0;
        victim_rep    = 1'b0;
        if (!slot.valid) begin
            if (!free_found_q) begin
                nx_free_found = 1'b1;
                nx_free_idx   = scan_idx;
            end
        end else begin
            // Strict compare: on equal age the lower index (seen first) wins.
            if (!any_found_q || (age > old_age_q)) begin
                nx_any_found = 1'b1;
                nx_old_idx   = scan_idx;
                nx_old_age   = age;
            end
            if ((slot.m == m_q) && (slot.n == n_q)) begin
                nx_same_cnt = same_cnt_q + CNT_W'(1);
                if ((same_cnt_q == '0) || (age > same_age_q)) begin
                    nx_same_idx = scan_idx;
                    nx_same_age = age;
                end
            end
        end
        if (32'(nx_same_cnt) >= MAX_PER_DIM) begin
            victim     = nx_same_idx;
            victim_rep = 1'b1;
        end else if (nx_free_found) begin
            victim     = nx_free_idx;
            victim_rep = 1'b0;
        end else begin
            victim     = nx_old_idx;
            victim_rep = 1'b1;
        end
    end

    // Control FSM, descriptor store and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            stamp_q        <= '0;
            m_q            <= '0;
            n_q            <= '0;
            scan_idx       <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
            any_found_q    <= 1'b0;
            old_idx_q      <= '0;
            old_age_q      <= '0;
            same_cnt_q     <= '0;
            same_idx_q     <= '0;
            same_age_q     <= '0;
            busy           <= 1'b0;
            bus.addr_ready <= 1'b0;
            bus.base_addr  <= '0;
            bus.alloc_id   <= '0;
            bus.replaced   <= 1'b0;
            bus.req_error  <= 1'b0;
            for (int i = 0; i < int'(MAX_MATS); i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            bus.addr_ready <= 1'b0;
            bus.replaced   <= 1'b0;
            bus.req_error  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (!dims_legal) begin
                            bus.req_error <= 1'b1;
                        end else begin
                            m_q          <= bus.req_m;
                            n_q          <= bus.req_n;
                            scan_idx     <= '0;
                            free_found_q <= 1'b0;
                            free_idx_q   <= '0;
                            any_found_q  <= 1'b0;
                            old_idx_q    <= '0;
                            old_age_q    <= '0;
                            same_cnt_q   <= '0;
                            same_idx_q   <= '0;
                            same_age_q   <= '0;
                            busy         <= 1'b1;
                            state_q      <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (bus.abort) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        free_found_q <= nx_free_found;
                        free_idx_q   <= nx_free_idx;
                        any_found_q  <= nx_any_found;
                        old_idx_q    <= nx_old_idx;
                        old_age_q    <= nx_old_age;
                        same_cnt_q   <= nx_same_cnt;
                        same_idx_q   <= nx_same_idx;
                        same_age_q   <= nx_same_age;
                        if (scan_idx == ID_W'(MAX_MATS - 1)) begin
                            bus.addr_ready        <= 1'b1;
                            bus.alloc_id          <= victim;
                            bus.base_addr         <= AW'(victim) * AW'(SLOT_WORDS);
                            bus.replaced          <= victim_rep;
                            desc_q[victim].valid  <= 1'b0;
                            state_q               <= GRANT;
                        end else begin
                            scan_idx <= scan_idx + ID_W'(1);
                        end
                    end
                end
                GRANT: begin
                    state_q <= WAIT_COMMIT;
                end
                WAIT_COMMIT: begin
                    // Commit has priority over a simultaneous abort.
                    if (bus.commit) begin
                        desc_q[bus.alloc_id] <= '{valid: 1'b1, m: m_q, n: n_q, stamp: stamp_q};
                        stamp_q              <= stamp_q + ST_W'(1);
                        busy                 <= 1'b0;
                        state_q              <= IDLE;
                    end else if (bus.abort) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Combinational descriptor lookup; out-of-range or invalid slots read as all zero.
    always_comb begin
        query_valid = 1'b0;
        query_m     = '0;
        query_n     = '0;
        query_base  = '0;
        if ((32'(query_id) < MAX_MATS) && desc_q[query_id].valid) begin
            query_valid = 1'b1;
            query_m     = desc_q[query_id].m;
            query_n     = desc_q[query_id].n;
            query_base  = AW'(query_id) * AW'(SLOT_WORDS);
        end
    end
endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Self-checking bench for matrix_slot_allocator: directed scenarios followed by a
// randomized request/commit/abort mix, checked against a slot-table reference model.
module tb_matrix_slot_allocator;
    localparam int MAX_MATS    = 16;
    localparam int SLOT_WORDS  = 25;
    localparam int MAX_PER_DIM = 2;
    localparam int LAT         = MAX_MATS + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [3:0] query_id;
    logic       query_valid;
    logic [2:0] query_m;
    logic [2:0] query_n;
    logic [8:0] query_base;

    always #5 clk = ~clk;

    matrix_slot_allocator_if bif ();

    matrix_slot_allocator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif),
        .busy        (busy),
        .query_id    (query_id),
        .query_valid (query_valid),
        .query_m     (query_m),
        .query_n     (query_n),
        .query_base  (query_base)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: slot table with commit stamps.
    bit mv [MAX_MATS];
    int mm [MAX_MATS];
    int mn [MAX_MATS];
    int ms [MAX_MATS];
    int mstamp;
    int g_id, g_m, g_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAX_MATS; i++) begin
            mv[i] = 1'b0; mm[i] = 0; mn[i] = 0; ms[i] = 0;
        end
        mstamp = 0;
    endtask

    function automatic int age_of(input int i);
        return (mstamp - ms[i]) & 255;
    endfunction

    // Victim by the allocation rules: shape limit, then first free, then oldest.
    function automatic int pick(input int m, input int n, output bit rep);
        int same_n, same_best, free, best;
        same_n = 0; same_best = -1; free = -1; best = -1;
        for (int i = 0; i < MAX_MATS; i++) begin
            if (!mv[i]) begin
                if (free < 0) free = i;
            end else begin
                if (best < 0 || age_of(i) > age_of(best)) best = i;
                if (mm[i] == m && mn[i] == n) begin
                    same_n++;
                    if (same_best < 0 || age_of(i) > age_of(same_best)) same_best = i;
                end
            end
        end
        if (same_n >= MAX_PER_DIM) begin rep = 1'b1; return same_best; end
        if (free >= 0) begin rep = 1'b0; return free; end
        rep = 1'b1;
        return best;
    endfunction

    task automatic check_query(input int id);
        query_id = 4'(id);
        #1;
        chk("q_valid", 32'(query_valid), 32'(mv[id]));
        if (mv[id]) begin
            chk("q_m", 32'(query_m), 32'(mm[id]));
            chk("q_n", 32'(query_n), 32'(mn[id]));
            chk("q_base", 32'(query_base), 32'(id * SLOT_WORDS));
        end
    endtask

    task automatic sweep();
        for (int i = 0; i < MAX_MATS; i++) check_query(i);
    endtask

    task automatic request(input int m, input int n);
        int  exp_id, edges;
        bit  exp_rep, got;
        exp_id = pick(m, n, exp_rep);
        bif.req_m = 3'(m); bif.req_n = 3'(n); bif.req_valid = 1'b1;
        edges = 0; got = 1'b0;
        while (!got && edges < LAT + 10) begin
            tick();
            edges++;
            if (bif.addr_ready === 1'b1) got = 1'b1;
        end
        bif.req_valid = 1'b0;
        chk("grant_seen", 32'(got), 32'd1);
        chk("latency", 32'(edges + 1), 32'(LAT));
        chk("alloc_id", 32'(bif.alloc_id), 32'(exp_id));
        chk("base_addr", 32'(bif.base_addr), 32'(exp_id * SLOT_WORDS));
        chk("replaced", 32'(bif.replaced), 32'(exp_rep));
        chk("busy_grant", 32'(busy), 32'd1);
        query_id = 4'(exp_id);
        #1;
        chk("grant_q_invalid", 32'(query_valid), 32'd0);
        mv[exp_id] = 1'b0;
        g_id = exp_id; g_m = m; g_n = n;
        tick();
        chk("ready_pulse", 32'(bif.addr_ready), 32'd0);
        chk("base_hold", 32'(bif.base_addr), 32'(exp_id * SLOT_WORDS));
    endtask

    task automatic commit_it(input bit with_abort);
        bif.commit = 1'b1; bif.abort = with_abort;
        tick();
        bif.commit = 1'b0; bif.abort = 1'b0;
        mv[g_id] = 1'b1; mm[g_id] = g_m; mn[g_id] = g_n; ms[g_id] = mstamp;
        mstamp = mstamp + 1;
        chk("busy_commit", 32'(busy), 32'd0);
    endtask

    task automatic abort_it();
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        chk("busy_abort", 32'(busy), 32'd0);
    endtask

    task automatic scan_abort(input int m, input int n, input int cycles);
        bif.req_m = 3'(m); bif.req_n = 3'(n); bif.req_valid = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        bif.req_valid = 1'b0;
        chk("busy_scan", 32'(busy), 32'd1);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        chk("scan_abort_busy", 32'(busy), 32'd0);
        chk("scan_abort_ready", 32'(bif.addr_ready), 32'd0);
    endtask

    task automatic illegal(input int m, input int n);
        bif.req_m = 3'(m); bif.req_n = 3'(n); bif.req_valid = 1'b1;
        tick();
        bif.req_valid = 1'b0;
        chk("req_error", 32'(bif.req_error), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        tick();
        chk("err_pulse", 32'(bif.req_error), 32'd0);
        chk("err_no_ready", 32'(bif.addr_ready), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        model_reset();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, m, n;
        bit dummy_rep;
        bif.req_valid = 1'b0; bif.req_m = '0; bif.req_n = '0;
        bif.commit = 1'b0; bif.abort = 1'b0; query_id = '0;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();

        // Reset state
        chk("rst_ready", 32'(bif.addr_ready), 32'd0);
        chk("rst_err", 32'(bif.req_error), 32'd0);
        chk("rst_rep", 32'(bif.replaced), 32'd0);
        chk("rst_base", 32'(bif.base_addr), 32'd0);
        chk("rst_id", 32'(bif.alloc_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        sweep();

        // T1: first allocation lands in slot 0
        request(2, 3);
        commit_it(1'b0);
        sweep();

        // T2: third same-shape matrix replaces the oldest
        do_reset();
        for (int k = 0; k < 3; k++) begin
            request(2, 2);
            commit_it(1'b0);
        end
        sweep();

        // T3: full table, new shape evicts the oldest overall
        do_reset();
        for (int k = 0; k < MAX_MATS; k++) begin
            request(k / 4 + 1, k % 4 + 1);
            commit_it(1'b0);
        end
        request(5, 5);
        commit_it(1'b0);
        sweep();

        // T4: illegal dimensions
        illegal(6, 2);
        illegal(0, 3);
        illegal(3, 7);
        illegal(5, 0);

        // T5: aborted grant leaves slot free for the next request
        do_reset();
        request(1, 1); commit_it(1'b0);
        request(1, 2); commit_it(1'b0);
        request(1, 3); abort_it();
        check_query(2);
        request(4, 4); commit_it(1'b0);
        sweep();

        // T6: commit beats abort; abort during scan; reset during scan
        request(3, 3);
        commit_it(1'b1);
        check_query(g_id);
        scan_abort(2, 2, 6);
        sweep();
        bif.req_m = 3'd2; bif.req_n = 3'd2; bif.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bif.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bif.addr_ready), 32'd0);
        model_reset();
        sweep();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized mix of requests, commits, aborts and lookups
        for (int it = 0; it < 70; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                m = ($urandom_range(0, 1) == 0) ? 0 : 6 + $urandom_range(0, 1);
                n = $urandom_range(1, 5);
                illegal(m, n);
            end else if (r == 1) begin
                scan_abort($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 15));
            end else begin
                request($urandom_range(1, 3), $urandom_range(1, 3));
                if ($urandom_range(0, 3) == 0) abort_it();
                else commit_it(1'($urandom_range(0, 1)));
            end
            check_query($urandom_range(0, MAX_MATS - 1));
        end
        sweep();
        void'(pick(1, 1, dummy_rep));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
